// File: rtl/cf_pkg.sv
// Shared types and default timing for the CompactFlash access sequencer.
package cf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_ACK,
    ST_DONE
  } cf_state_e;

  localparam int T_SETUP_DEF   = 2;
  localparam int T_STROBE_DEF  = 6;
  localparam int T_HOLD_DEF    = 2;
  localparam int WAIT_MAX_DEF  = 255;
  localparam int DB_CYCLES_DEF = 50000;

  localparam int CNT_W = 16;

  localparam logic [7:0] IDLE_DATA = 8'hFF;

endpackage

// File: rtl/cf_access_sequencer_if.sv
// Minibus and CF card signal bundle; slave is the sequencer, master is the host/card side.
interface cf_access_sequencer_if;

  logic        ale;
  logic        rw_b;
  logic [19:0] address;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic        ta_b;

  logic [7:0]  cf_data_in;
  logic        cf_wait_b;
  logic [1:0]  cf_cd;
  logic        cf_ce;
  logic        cf_oe;
  logic        cf_we;
  logic        cf_reg;
  logic [10:0] cf_address;
  logic [7:0]  cf_data_out;
  logic        cf_data_oe;

  logic        card_present;
  logic        err;

  modport master (
    output ale, rw_b, address, wr_data, cf_data_in, cf_wait_b, cf_cd,
    input  rd_data, ta_b, cf_ce, cf_oe, cf_we, cf_reg, cf_address,
           cf_data_out, cf_data_oe, card_present, err
  );

  modport slave (
    input  ale, rw_b, address, wr_data, cf_data_in, cf_wait_b, cf_cd,
    output rd_data, ta_b, cf_ce, cf_oe, cf_we, cf_reg, cf_address,
           cf_data_out, cf_data_oe, card_present, err
  );

endinterface

// File: rtl/cf_cd_debounce.sv
// Card-detect synchronizer and stability down-counter; card is present when both pins read low.
module cf_cd_debounce
  import cf_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] cf_cd_i,
  output logic       card_present_o
);

  localparam int DB_W = $clog2(DB_CYCLES + 1);

  logic [1:0]      s1_q;
  logic [1:0]      s2_q;
  logic [1:0]      prev_q;
  logic [DB_W-1:0] cnt_q;
  logic            present_q;

  // Any change of the synchronized pins reloads the timer; status follows only at terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= 2'b11;
      s2_q      <= 2'b11;
      prev_q    <= 2'b11;
      cnt_q     <= '0;
      present_q <= 1'b0;
    end else begin
      s1_q   <= cf_cd_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      if (s2_q != prev_q) begin
        cnt_q <= DB_W'(DB_CYCLES - 1);
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - DB_W'(1);
      end else begin
        present_q <= (prev_q == 2'b00);
      end
    end
  end

  assign card_present_o = present_q;

endmodule

// File: rtl/cf_access_sequencer.sv
// Converts asynchronous minibus accesses into timed CF card read/write strobes with WAIT# extension.
//
// state  | meaning
// IDLE   | waiting for a synchronized ale falling edge
// SETUP  | cf_ce low, address/REG# stable before the strobe
// STROBE | cf_oe or cf_we low, stretched by WAIT#, aborted after WAIT_MAX
// HOLD   | strobe released, cf_ce (and write data) held
// ACK    | single-cycle ta_b pulse
// DONE   | waiting for ale to return high
module cf_access_sequencer
  import cf_pkg::*;
#(
  parameter int T_SETUP   = T_SETUP_DEF,
  parameter int T_STROBE  = T_STROBE_DEF,
  parameter int T_HOLD    = T_HOLD_DEF,
  parameter int WAIT_MAX  = WAIT_MAX_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  cf_access_sequencer_if.slave  bus
);

  logic [1:0]  ale_s_q;
  logic [1:0]  wait_s_q;
  logic        ale_prev_q;
  logic        ale_sync;
  logic        wait_sync;
  logic        ale_fall;
  logic        card_present;

  cf_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ext_q, ext_d;
  logic        rw_q, rw_d;
  logic        reg_q, reg_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  rd_q, rd_d;
  logic        err_q, err_d;
  logic        ce_q, ce_d;
  logic        oe_q, oe_d;
  logic        we_q, we_d;
  logic        doe_q, doe_d;
  logic        ta_q, ta_d;

  logic        unused_addr;
  assign unused_addr = ^{bus.address[19:13], bus.address[11]};

  cf_cd_debounce #(.DB_CYCLES(DB_CYCLES)) u_cd_debounce (
    .clk            (clk),
    .reset          (reset),
    .cf_cd_i        (bus.cf_cd),
    .card_present_o (card_present)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ale_s_q    <= 2'b11;
      wait_s_q   <= 2'b11;
      ale_prev_q <= 1'b1;
    end else begin
      ale_s_q    <= {ale_s_q[0], bus.ale};
      wait_s_q   <= {wait_s_q[0], bus.cf_wait_b};
      ale_prev_q <= ale_s_q[1];
    end
  end

  assign ale_sync  = ale_s_q[1];
  assign wait_sync = wait_s_q[1];
  assign ale_fall  = ale_prev_q & ~ale_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ext_q   <= '0;
      rw_q    <= 1'b1;
      reg_q   <= 1'b1;
      addr_q  <= '0;
      dout_q  <= '0;
      rd_q    <= IDLE_DATA;
      err_q   <= 1'b0;
      ce_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      doe_q   <= 1'b0;
      ta_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ext_q   <= ext_d;
      rw_q    <= rw_d;
      reg_q   <= reg_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      ce_q    <= ce_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      doe_q   <= doe_d;
      ta_q    <= ta_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ext_d   = ext_q;
    rw_d    = rw_q;
    reg_d   = reg_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rd_d    = rd_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ale_fall) begin
          rw_d   = bus.rw_b;
          reg_d  = bus.address[12];
          addr_d = bus.address[10:0];
          dout_d = bus.wr_data;
          if (card_present) begin
            state_d = ST_SETUP;
            cnt_d   = CNT_W'(T_SETUP - 1);
          end else begin
            state_d = ST_ACK;
            rd_d    = IDLE_DATA;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = CNT_W'(T_STROBE - 1);
          ext_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // Minimum width runs first; WAIT# only stretches once it has elapsed.
      ST_STROBE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (wait_sync) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(T_HOLD - 1);
          if (rw_q) rd_d = bus.cf_data_in;
        end else if (ext_q == CNT_W'(WAIT_MAX)) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(T_HOLD - 1);
          err_d   = 1'b1;
          rd_d    = IDLE_DATA;
        end else begin
          ext_d = ext_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) state_d = ST_ACK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_ACK:  state_d = ST_DONE;
      ST_DONE: if (ale_sync) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they toggle glitch-free with it.
    ce_d  = !(state_d inside {ST_SETUP, ST_STROBE, ST_HOLD});
    oe_d  = !((state_d == ST_STROBE) && rw_d);
    we_d  = !((state_d == ST_STROBE) && !rw_d);
    doe_d = (state_d inside {ST_STROBE, ST_HOLD}) && !rw_d;
    ta_d  = !(state_d == ST_ACK);
  end

  assign bus.rd_data      = rd_q;
  assign bus.ta_b         = ta_q;
  assign bus.cf_ce        = ce_q;
  assign bus.cf_oe        = oe_q;
  assign bus.cf_we        = we_q;
  assign bus.cf_reg       = reg_q;
  assign bus.cf_address   = addr_q;
  assign bus.cf_data_out  = dout_q;
  assign bus.cf_data_oe   = doe_q;
  assign bus.card_present = card_present;
  assign bus.err          = err_q;

endmodule

// File: doc/cf_access_sequencer.md
CF_ACCESS_SEQUENCER -- requirements
Module: cf_access_sequencer

Interface
REQ-001 Parameter T_SETUP, 2, clk cycles from cf_ce low to strobe low (min 1).
REQ-002 Parameter T_STROBE, 6, minimum clk cycles cf_oe/cf_we held low (min 1).
REQ-003 Parameter T_HOLD, 2, clk cycles from strobe high to cf_ce high (min 1).
REQ-004 Parameter WAIT_MAX, 255, maximum cf_wait_b-extended strobe cycles before abort.
REQ-005 Parameter DB_CYCLES, 50000, card-detect debounce stability time in clk cycles.
REQ-006 clk  in  1  system clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 ale  in  1  minibus chip select, active low, asynchronous to clk.
REQ-009 rw_b  in  1  1 = read, 0 = write; sampled with ale.
REQ-010 address  in  20  minibus address; bit 12 selects attribute/IO space.
REQ-011 wr_data  in  8  minibus write data.
REQ-012 cf_data_in  in  8  CF card read data.
REQ-013 cf_wait_b  in  1  CF WAIT#, active low, asynchronous.
REQ-014 cf_cd  in  2  CF card-detect pins, active low, asynchronous.
REQ-015 rd_data  out  8  read data returned to minibus.
REQ-016 ta_b  out  1  transfer acknowledge, active low, one clk pulse.
REQ-017 cf_ce, cf_oe, cf_we  out  1 each  CF card enable, output enable, write enable, active low.
REQ-018 cf_reg  out  1  CF REG# from latched address[12].
REQ-019 cf_address  out  11  latched address[10:0].
REQ-020 cf_data_out  out  8, cf_data_oe  out  1  write data and its drive enable.
REQ-021 card_present  out  1  debounced card-detect status; err  out  1  sticky timeout flag.

Function
REQ-022 ale, cf_wait_b, and both cf_cd bits SHALL each pass through a two-flop synchronizer; all decisions use the synchronized values.
REQ-023 Start condition: synchronized ale high-to-low edge while FSM in IDLE; address, rw_b, wr_data latched in that cycle.
REQ-024 FSM states: IDLE, SETUP, STROBE, HOLD, ACK, DONE.
REQ-025 Card absent at start: IDLE->ACK directly, no CF strobe, rd_data = 8'hFF.
REQ-026 SETUP: cf_ce=0, cf_reg/cf_address valid, T_SETUP cycles, then STROBE.
REQ-027 STROBE: cf_oe=0 (read) or cf_we=0 plus cf_data_oe=1 (write); lasts T_STROBE cycles, extended while synchronized cf_wait_b=0.
REQ-028 Read data SHALL be captured into rd_data on the final STROBE cycle.
REQ-029 Extension beyond WAIT_MAX cycles: strobe released, err set, rd_data = 8'hFF, proceed to HOLD.
REQ-030 HOLD: strobes high, cf_ce=0, cf_data_oe stays 1 for writes, T_HOLD cycles, then ACK.
REQ-031 ACK: ta_b=0 for exactly one cycle, cf_ce=1, then DONE.
REQ-032 DONE: wait for synchronized ale=1, then IDLE; no new access without a fresh ale falling edge.
REQ-033 Early ale deassertion (ale high before ACK): access SHALL complete full timing and ACK anyway.
REQ-034 card_present SHALL change only after both cf_cd bits hold a consistent value (both low = present, otherwise absent) for DB_CYCLES consecutive cycles; counter restarts on any change.
REQ-035 Card removal during an access: FSM completes the current access unchanged; card_present affects only the next start.
REQ-036 err clears only on reset.

Reset
REQ-037 On reset: FSM=IDLE, cf_ce=cf_oe=cf_we=1, cf_data_oe=0, ta_b=1, cf_reg=1, cf_address=0, cf_data_out=0, rd_data=8'hFF, err=0, card_present=0, synchronizers=1, counters=0.
REQ-038 Reset asserted mid-access SHALL release all CF strobes immediately (asynchronously) with no ACK issued.

Structure
REQ-039 Shared package cf_pkg holds the FSM state enum, default timing constants, and the 8'hFF idle-data constant.
REQ-040 One sub-module, cf_cd_debounce (synchronizer plus counter), produces card_present.

Verification
REQ-041 Card present, read, defaults, cf_data_in=8'h5A -> cf_ce low 10 cycles, cf_oe low 6 cycles, rd_data=8'h5A, one ta_b pulse.
REQ-042 Write with wr_data=8'hC3 and address[12]=1 -> cf_reg=1, cf_we low 6 cycles, cf_data_out=8'hC3 with cf_data_oe=1 through HOLD.
REQ-043 cf_wait_b low for 20 cycles during STROBE -> strobe low 22 cycles; with cf_wait_b held low -> abort after 255 cycles, err=1, rd_data=8'hFF.
REQ-044 cf_cd=2'b00 glitching every 1000 cycles -> card_present stays 0; held stable for 50000 cycles -> card_present=1.
REQ-045 Card absent, read -> ta_b pulse 3 cycles after ale edge (sync plus state), rd_data=8'hFF, cf_ce never low.
REQ-046 Reset asserted in STROBE -> cf_oe/cf_ce high the same cycle, no ta_b, next access behaves normally.
